// File: rtl/stage3_ifetch_prefetch_buffer.sv
// Sequential fetch prefetch queue: one outstanding word read, DEPTH-entry queue, redirect flushes and drops in-flight data.
// Latency: queue-head hit in the request cycle, empty-queue miss in memory latency. Backpressure: fetch waits on f_busy; prefetch stops when full.
module stage3_ifetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         f_ren,
    input  logic [31:0]                  f_addr,
    output logic [31:0]                  f_rdata,
    output logic                         f_busy,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_addr,
    output logic [31:0]                  m_addr,
    output logic                         m_ren,
    input  logic [31:0]                  m_rdata,
    input  logic                         m_busy,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {S_REQ, S_DISCARD} state_t;

    state_t        state;
    logic [31:0]   pf_addr;
    logic [31:0]   disc_addr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [29:0]   q_tag [DEPTH];
    logic [31:0]   q_dat [DEPTH];

    logic in_req, q_empty, head_match, hit, mem_req, mem_done;
    logic bypass, iflush, flush, push;
    logic unused_ok;

    assign unused_ok = ^{f_addr[1:0], redirect_addr[1:0]};

    assign in_req     = (state == S_REQ);
    assign q_empty    = (q_count == '0);
    assign head_match = (q_tag[rd_ptr] == f_addr[31:2]);
    assign hit        = f_ren & ~q_empty & head_match & ~redirect;
    // A pop frees a slot this cycle, so a full queue may still issue alongside it.
    assign mem_req    = in_req ? ((q_count != FULL) | hit) : 1'b1;
    assign mem_done   = mem_req & ~m_busy;
    assign bypass     = f_ren & q_empty & in_req & mem_done & ~redirect
                      & (pf_addr[31:2] == f_addr[31:2]);
    // An empty-queue mismatch waits for any access in flight rather than abandoning it.
    assign iflush     = f_ren & in_req & ~redirect
                      & (q_empty ? (~m_busy & (pf_addr[31:2] != f_addr[31:2])) : ~head_match);
    assign flush      = redirect | iflush;
    assign push       = in_req & mem_done & ~flush & ~bypass;

    assign m_ren   = ~RST & mem_req;
    assign m_addr  = in_req ? pf_addr : disc_addr;
    assign f_busy  = RST | ~(hit | bypass);
    assign f_rdata = RST    ? 32'h0 :
                     hit    ? q_dat[rd_ptr] :
                     bypass ? m_rdata : 32'h0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_REQ;
            pf_addr   <= RESET_PC;
            disc_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            q_count   <= '0;
        end else if (flush) begin
            state     <= (mem_req & m_busy) ? S_DISCARD : S_REQ;
            disc_addr <= m_addr;
            pf_addr   <= redirect ? {redirect_addr[31:2], 2'b00} : {f_addr[31:2], 2'b00};
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            q_count   <= '0;
        end else if (!in_req) begin
            if (!m_busy) begin
                state <= S_REQ;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (hit) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            q_count <= q_count + CW'(push) - CW'(hit);
            if (mem_done) begin
                pf_addr <= pf_addr + 32'd4;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_tag[wr_ptr] <= pf_addr[31:2];
            q_dat[wr_ptr] <= m_rdata;
        end
    end

endmodule
